test_i7009: RTL and testbench

Small synchronous logic benchmark block with five single-bit inputs and one registered single-bit output. Inputs are registered, passed through a fixed Boolean core function, and registered again onto the output. An optional rare-pattern trigger monitor can be compiled in; when it fires, it inverts the output until reset. The block sits as a leaf cell in the benchmark test set and is exercised exhaustively over all 32 input codes.

---
 rtl/test_i7009.sv | 66 ++++++
 tb/tb_test_i7009.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/test_i7009.sv
// Two-stage registered benchmark cell: registered inputs, majority/AND-XOR core, registered output.
// Optional rare-pattern trigger monitor enabled by defining RARE_TRIGGER_EN.
module test_i7009 (
    input  logic N0,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic N4,
    input  logic CK,
    input  logic reset,
    output logic Y
);

    localparam int unsigned NIN   = 5;
    localparam int unsigned CNT_W = 3;

    // r_nq[4] holds N0 (MSB of the input literal), r_nq[0] holds N4
    logic [NIN-1:0] r_nq;
    logic           w_maj;
    logic           w_and;
    logic           w_f;
    logic           w_trig;

    always_ff @(posedge CK) begin
        if (reset) begin
            r_nq <= '0;
        end else begin
            r_nq <= {N0, N1, N2, N3, N4};
        end
    end

    assign w_maj = (r_nq[4] & r_nq[3]) | (r_nq[3] & r_nq[2]) | (r_nq[4] & r_nq[2]);
    assign w_and = r_nq[1] & r_nq[0];
    assign w_f   = w_maj ^ w_and;

`ifdef RARE_TRIGGER_EN
    localparam logic [NIN-1:0]   TRIG_PAT = NIN'(5'b10110);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(7);

    logic [CNT_W-1:0] r_cnt;
    logic             w_match;

    assign w_match = (r_nq == TRIG_PAT);
    assign w_trig  = (r_cnt == CNT_MAX);

    // Saturating match counter; once it reaches its ceiling the trigger stays set until reset
    always_ff @(posedge CK) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_match && !w_trig) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_trig = 1'b0;
`endif

    always_ff @(posedge CK) begin
        if (reset) begin
            Y <= 1'b0;
        end else begin
            Y <= w_f ^ w_trig;
        end
    end

endmodule

// File: tb/tb_test_i7009.sv
// Self-checking bench for test_i7009: directed scenarios plus randomized stimulus against a
// history-based reference model. Honours RARE_TRIGGER_EN when defined for the build.
module tb_test_i7009;

    logic N0, N1, N2, N3, N4;
    logic CK;
    logic reset;
    logic Y;

    int n_cmp;
    int n_bad;

    localparam logic [4:0] PAT = 5'b10110;
`ifdef RARE_TRIGGER_EN
    localparam bit TRIG_ON = 1'b1;
`else
    localparam bit TRIG_ON = 1'b0;
`endif

    // Values held by the input register after each edge since the last reset (index 0 = reset edge)
    logic [4:0] hist[$];
    logic       exp_y;

    test_i7009 dut (
        .N0    (N0),
        .N1    (N1),
        .N2    (N2),
        .N3    (N3),
        .N4    (N4),
        .CK    (CK),
        .reset (reset),
        .Y     (Y)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Spec-level core function on a literal whose bit 4 is N0
    function automatic logic f_of(input logic [4:0] c);
        int ones;
        ones = int'(c[4]) + int'(c[3]) + int'(c[2]);
        return logic'(ones >= 2) ^ (c[1] & c[0]);
    endfunction

    // Drive one edge and advance the reference model; Y is sampled 1 time unit after the edge
    task automatic step(input logic [4:0] code, input logic rst);
        int m;
        {N0, N1, N2, N3, N4} = code;
        reset = rst;
        @(posedge CK);
        #1;
        if (rst) begin
            hist.delete();
            hist.push_back(5'd0);
            exp_y = 1'b0;
        end else begin
            m = 0;
            for (int i = 0; i < hist.size() - 1; i++)
                if (hist[i] == PAT) m++;
            exp_y = f_of(hist[hist.size() - 1]) ^ (TRIG_ON && (m >= 7));
            hist.push_back(code);
        end
    endtask

    task automatic test_reset();
        step(5'($urandom_range(0, 31)), 1'b1);
        n_cmp++;
        if (Y !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_y: got %b expected 0", Y);
        end
        for (int e = 0; e < 5; e++) begin
            step(5'b00000, 1'b0);
            n_cmp++;
            if (Y !== 1'b0) begin
                n_bad++;
                $display("FAIL zeros_hold edge %0d: got %b expected 0", e, Y);
            end
        end
    endtask

    task automatic test_latency();
        step(5'b11000, 1'b0);
        n_cmp++;
        if (Y !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_edge_k: got %b expected 0", Y);
        end
        step(5'b11000, 1'b0);
        n_cmp++;
        if (Y !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_edge_k1: got %b expected 1", Y);
        end
    endtask

    task automatic test_examples();
        logic [4:0] codes [5];
        logic       vals  [5];
        codes = '{5'b11000, 5'b00011, 5'b11111, 5'b10101, 5'b01111};
        vals  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(codes[i], 1'b0);
            step(codes[i], 1'b0);
            n_cmp++;
            if (Y !== vals[i]) begin
                n_bad++;
                $display("FAIL example %b: got %b expected %b", codes[i], Y, vals[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        step(5'b00000, 1'b1);
        for (int c = 0; c < 32; c++) begin
            step(5'(c), 1'b0);
            step(5'(c), 1'b0);
            n_cmp++;
            if (Y !== exp_y || Y !== f_of(5'(c))) begin
                n_bad++;
                $display("FAIL sweep %b: got %b expected %b", 5'(c), Y, exp_y);
            end
        end
    endtask

    task automatic test_mid_reset();
        step(5'b11000, 1'b0);
        step(5'b11000, 1'b0);
        n_cmp++;
        if (Y !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_pre: got %b expected 1", Y);
        end
        step(5'b11000, 1'b1);
        n_cmp++;
        if (Y !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_on: got %b expected 0", Y);
        end
        step(5'b11000, 1'b0);
        n_cmp++;
        if (Y !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_post1: got %b expected 0", Y);
        end
        step(5'b11000, 1'b0);
        n_cmp++;
        if (Y !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_post2: got %b expected 1", Y);
        end
    endtask

    task automatic test_trigger();
        logic want;
        step(5'b00000, 1'b1);
        for (int e = 1; e <= 20; e++) begin
            step(PAT, 1'b0);
            want = (e == 1) ? 1'b0 : (TRIG_ON && e >= 9) ? 1'b0 : 1'b1;
            n_cmp++;
            if (Y !== want || Y !== exp_y) begin
                n_bad++;
                $display("FAIL trig_hold edge %0d: got %b expected %b model %b", e, Y, want, exp_y);
            end
        end
        for (int e = 0; e < 3; e++) step(5'b00000, 1'b0);
        n_cmp++;
        if (Y !== TRIG_ON) begin
            n_bad++;
            $display("FAIL trig_zeros: got %b expected %b", Y, TRIG_ON);
        end
        step(5'b00000, 1'b1);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b0);
        n_cmp++;
        if (Y !== 1'b0) begin
            n_bad++;
            $display("FAIL trig_cleared: got %b expected 0", Y);
        end
    endtask

    task automatic test_random();
        logic [4:0] code;
        logic       rst;
        step(5'b00000, 1'b1);
        for (int e = 0; e < 400; e++) begin
            code = ($urandom_range(0, 3) == 0) ? PAT : 5'($urandom_range(0, 31));
            rst  = ($urandom_range(0, 79) == 0);
            step(code, rst);
            n_cmp++;
            if (Y !== exp_y) begin
                n_bad++;
                $display("FAIL random edge %0d code %b rst %b: got %b expected %b", e, code, rst, Y, exp_y);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_y = 1'b0;
        {N0, N1, N2, N3, N4} = 5'b00000;
        reset = 1'b1;
        test_reset();
        test_latency();
        test_examples();
        test_exhaustive();
        test_mid_reset();
        test_trigger();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
